set_host: RTL and testbench

SET_HOST -- requirements
Module: set_host

---
 rtl/set_host.sv | 175 +++++++++++++++++
 tb/tb_set_host.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/set_host.sv
// Job host for the set-counter engine: queues jobs, issues them one at a time, collects results.
// Latency: push to set_en is 2 cycles; result handshake to next set_en is 2 cycles minimum.
// Backpressure: job_ready is deasserted while the queue is full; res_* are held until res_ready.
module set_host #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [23:0] job_central,
    input  logic [11:0] job_radius,
    input  logic [1:0]  job_mode,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_candidate,
    output logic [1:0]  res_mode,
    output logic        res_timeout,
    output logic [7:0]  jobs_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    typedef struct packed {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } job_t;

    job_t          fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    job_t          head;
    logic          push, pop;

    logic [1:0]  state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [23:0] set_central_q, set_central_d;
    logic [11:0] set_radius_q, set_radius_d;
    logic [1:0]  set_mode_q, set_mode_d;
    logic [7:0]  res_candidate_q, res_candidate_d;
    logic [1:0]  res_mode_q, res_mode_d;
    logic        res_timeout_q, res_timeout_d;
    logic [7:0]  jobs_done_q, jobs_done_d;

    assign job_ready = (count_q < DEPTH_C);
    assign push      = job_valid && job_ready;
    assign pop       = (state_q == S_ISSUE);
    assign head      = fifo_q[rptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {job_central, job_radius, job_mode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Operands are loaded on the edge into ISSUE so they are already valid while set_en is high.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        set_central_d   = set_central_q;
        set_radius_d    = set_radius_q;
        set_mode_d      = set_mode_q;
        res_candidate_d = res_candidate_q;
        res_mode_d      = res_mode_q;
        res_timeout_d   = res_timeout_q;
        jobs_done_d     = jobs_done_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !set_busy) begin
                    state_d       = S_ISSUE;
                    set_central_d = head.central;
                    set_radius_d  = head.radius;
                    set_mode_d    = head.mode;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (set_valid) begin
                    res_candidate_d = set_candidate;
                    res_mode_d      = set_mode_q;
                    res_timeout_d   = 1'b0;
                    state_d         = S_RESULT;
                end else if (timer_q == TMO_LAST) begin
                    res_candidate_d = '0;
                    res_mode_d      = set_mode_q;
                    res_timeout_d   = 1'b1;
                    state_d         = S_RESULT;
                end
            end
            default: begin
                if (res_ready) begin
                    jobs_done_d = jobs_done_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            set_central_q   <= '0;
            set_radius_q    <= '0;
            set_mode_q      <= '0;
            res_candidate_q <= '0;
            res_mode_q      <= '0;
            res_timeout_q   <= 1'b0;
            jobs_done_q     <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            set_central_q   <= set_central_d;
            set_radius_q    <= set_radius_d;
            set_mode_q      <= set_mode_d;
            res_candidate_q <= res_candidate_d;
            res_mode_q      <= res_mode_d;
            res_timeout_q   <= res_timeout_d;
            jobs_done_q     <= jobs_done_d;
        end
    end

    assign set_en        = (state_q == S_ISSUE);
    assign res_valid     = (state_q == S_RESULT);
    assign set_central   = set_central_q;
    assign set_radius    = set_radius_q;
    assign set_mode      = set_mode_q;
    assign res_candidate = res_candidate_q;
    assign res_mode      = res_mode_q;
    assign res_timeout   = res_timeout_q;
    assign jobs_done     = jobs_done_q;

endmodule

// File: tb/tb_set_host.sv
// Bench for set_host: directed scenarios with random operands, a job queue model and an engine model.
module tb_set_host;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [23:0] job_central = '0;
    logic [11:0] job_radius = '0;
    logic [1:0]  job_mode = '0;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy = 1'b0;
    logic        set_valid = 1'b0;
    logic [7:0]  set_candidate = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_candidate;
    logic [1:0]  res_mode;
    logic        res_timeout;
    logic [7:0]  jobs_done;

    set_host #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_candidate(res_candidate), .res_mode(res_mode), .res_timeout(res_timeout),
        .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
    } job_t;

    job_t       q[$];
    logic [7:0] exp_done = '0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        logic exp_rdy;
        job_t j;
        exp_rdy = (q.size() < DEPTH);
        job_valid = 1'b1; job_central = c; job_radius = r; job_mode = m;
        chk("job_ready", 32'(job_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            j.c = c; j.r = r; j.m = m;
            q.push_back(j);
        end
        tick();
        job_valid = 1'b0;
    endtask

    task automatic push_rand();
        push_job(24'($urandom), 12'($urandom), 2'($urandom));
    endtask

    // Engine model: answers after 'delay' cycles (or never), then optionally stalls the handshake.
    task automatic serve(input int delay, input bit give_valid, input int hold, input int cand_in);
        int n;
        job_t j;
        logic [7:0] cand, exp_c;
        logic exp_to;
        n = 0;
        while (set_en !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("set_en_seen", 32'(set_en), 1);
        j = q.pop_front();
        chk("set_central", 32'(set_central), 32'(j.c));
        chk("set_radius", 32'(set_radius), 32'(j.r));
        chk("set_mode", 32'(set_mode), 32'(j.m));
        cand = (cand_in < 0) ? 8'($urandom) : 8'(cand_in);
        tick();
        chk("set_en_single", 32'(set_en), 0);
        if (give_valid) begin
            for (int i = 1; i < delay; i++) tick();
            chk("res_early", 32'(res_valid), 0);
            chk("oper_held", 32'(set_central), 32'(j.c));
            set_valid = 1'b1; set_candidate = cand;
            tick();
            set_valid = 1'b0; set_candidate = 8'($urandom);
            exp_c = cand; exp_to = 1'b0;
        end else begin
            for (int i = 1; i < TMO; i++) tick();
            chk("tmo_early", 32'(res_valid), 0);
            tick();
            exp_c = 8'd0; exp_to = 1'b1;
        end
        chk("res_valid", 32'(res_valid), 1);
        chk("res_candidate", 32'(res_candidate), 32'(exp_c));
        chk("res_timeout", 32'(res_timeout), 32'(exp_to));
        if (give_valid) chk("res_mode", 32'(res_mode), 32'(j.m));
        for (int i = 0; i < hold; i++) begin
            if (i == hold / 2) begin
                set_valid = 1'b1; set_candidate = 8'h55;
            end
            tick();
            set_valid = 1'b0;
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_cand", 32'(res_candidate), 32'(exp_c));
            chk("hold_no_issue", 32'(set_en), 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_done = exp_done + 8'd1;
        chk("jobs_done", 32'(jobs_done), 32'(exp_done));
        chk("res_released", 32'(res_valid), 0);
        chk("issue_m1", 32'(set_en), 0);
        if (q.size() > 0 && !set_busy) begin
            tick();
            chk("issue_m2", 32'(set_en), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_res, seen_en;
        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_job_ready", 32'(job_ready), 1);
        chk("rst_set_en", 32'(set_en), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_jobs_done", 32'(jobs_done), 0);
        chk("rst_set_central", 32'(set_central), 0);
        chk("rst_res_candidate", 32'(res_candidate), 0);

        // Single job, exact issue latency, 66-cycle engine answer
        push_job(24'h345678, 12'h234, 2'd1);
        chk("lat_n1", 32'(set_en), 0);
        tick();
        chk("lat_n2", 32'(set_en), 1);
        serve(66, 1'b1, 0, 8'h0C);

        // Queue fill while engine busy, then release and drain in order
        set_busy = 1'b1;
        for (int i = 0; i < 5; i++) push_rand();
        for (int i = 0; i < 3; i++) begin
            chk("busy_no_issue", 32'(set_en), 0);
            tick();
        end
        set_busy = 1'b0;
        chk("busy_release_0", 32'(set_en), 0);
        tick();
        chk("busy_release_1", 32'(set_en), 1);
        serve(int'($urandom_range(1, 40)), 1'b1, 10, -1);
        for (int i = 0; i < 3; i++) serve(int'($urandom_range(1, 40)), 1'b1, 0, -1);

        // Timeout
        push_rand();
        serve(0, 1'b0, 0, -1);

        // Many short jobs, carrying jobs_done through 255 -> 0
        while (exp_done != 8'd1) begin
            push_rand();
            serve(int'($urandom_range(1, 3)), 1'b1, int'($urandom_range(0, 1)), -1);
        end

        // Reset during WAIT_VALID with two jobs queued
        push_rand();
        tick();
        chk("rw_issue", 32'(set_en), 1);
        void'(q.pop_front());
        tick(); tick();
        push_rand();
        push_rand();
        rst = 1'b1;
        job_valid = 1'b1; job_central = 24'hABCDEF; job_radius = 12'h321; job_mode = 2'd2;
        tick();
        rst = 1'b0;
        job_valid = 1'b0;
        q.delete();
        exp_done = '0;
        chk("rr_job_ready", 32'(job_ready), 1);
        chk("rr_set_en", 32'(set_en), 0);
        chk("rr_set_central", 32'(set_central), 0);
        chk("rr_set_radius", 32'(set_radius), 0);
        chk("rr_set_mode", 32'(set_mode), 0);
        chk("rr_res_valid", 32'(res_valid), 0);
        chk("rr_res_candidate", 32'(res_candidate), 0);
        chk("rr_res_mode", 32'(res_mode), 0);
        chk("rr_res_timeout", 32'(res_timeout), 0);
        chk("rr_jobs_done", 32'(jobs_done), 0);
        seen_res = 1'b0;
        seen_en = 1'b0;
        for (int i = 0; i < 260; i++) begin
            set_valid = (i == 5);
            set_candidate = 8'h77;
            if (res_valid === 1'b1) seen_res = 1'b1;
            if (set_en === 1'b1) seen_en = 1'b1;
            tick();
        end
        set_valid = 1'b0;
        chk("rr_no_result", 32'(seen_res), 0);
        chk("rr_no_issue", 32'(seen_en), 0);
        chk("rr_done_zero", 32'(jobs_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
